start_sequencer: RTL and testbench

Consumes the debounced start-button output and turns each press into exactly one start handshake toward the processing core. Presses that arrive while the core is busy are queued, up to a bounded depth. After each completion, a done indication is held for a fixed display time so it is visible on a board LED. Sits between the debouncer and the core's start/done interface on the DE2-115 top level.

---
 rtl/start_sequencer.sv | 170 +++++++++++++++++
 tb/tb_start_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/start_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : start_sequencer
//  Purpose  : Turns debounced start-button presses into one start handshake
//             each toward the processing core. Queues presses while the core
//             is busy and holds a done indication for a fixed display time.
//  Options  : START_SEQ_TIMEOUT_EN - builds a WAIT_DONE watchdog that sets
//             timeout_o and returns to IDLE if core_done never arrives.
//  Revision : 1.0 - initial release
// ============================================================================
module start_sequencer #(
  parameter int unsigned PEND_MAX       = 3,
  parameter int unsigned HOLD_CYCLES    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       db_in,
  input  logic       core_ready,
  input  logic       core_done,
  input  logic       clr_err,
  output logic       start_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] pend_o,
  output logic [7:0] launches_o,
  output logic       ovf_o,
  output logic       timeout_o
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LAUNCH    = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;
  localparam logic [1:0] S_HOLD      = 2'd3;

  // Hold counter is sized to reach HOLD_CYCLES-1; a single bit covers HOLD_CYCLES=1.
  localparam int unsigned  c_HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [3:0]   c_PEND_MAX  = 4'(PEND_MAX);

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic                r_db_q;
  logic [3:0]          r_pend;
  logic [7:0]          r_launches;
  logic                r_ovf;
  logic                r_timeout;
  logic [c_HOLD_W-1:0] r_hold;
  logic                w_press;
  logic                w_accept;
  logic                w_full;
  logic                w_wd_expire;

  assign w_press  = db_in & ~r_db_q;
  assign w_accept = (r_state == S_LAUNCH) & core_ready;
  assign w_full   = (r_pend >= c_PEND_MAX);

`ifdef START_SEQ_TIMEOUT_EN
  localparam int unsigned c_WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);

  logic [c_WD_W-1:0] r_wd;

  assign w_wd_expire = (r_state == S_WAIT_DONE) & ~core_done & (r_wd == c_WD_LAST);

  // Watchdog: counts cycles in WAIT_DONE, held at zero elsewhere so each entry starts fresh
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd <= '0;
    end else if (r_state != S_WAIT_DONE || core_done || w_wd_expire) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + 1'b1;
    end
  end
`else
  assign w_wd_expire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_pend != 4'd0) w_next_state = S_LAUNCH;
      end
      S_LAUNCH: begin
        if (core_ready) w_next_state = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (core_done)        w_next_state = S_HOLD;
        else if (w_wd_expire) w_next_state = S_IDLE;
      end
      S_HOLD: begin
        if (r_hold == '0) w_next_state = (r_pend != 4'd0) ? S_LAUNCH : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register
  always_comb begin
    start_o = (r_state == S_LAUNCH);
    busy_o  = (r_state != S_IDLE);
    done_o  = (r_state == S_HOLD);
  end

  // Button edge register for press detection
  always_ff @(posedge clk) begin
    if (rst) r_db_q <= 1'b0;
    else     r_db_q <= db_in;
  end

  // Press queue: a simultaneous press and accept cancel and never overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= 4'd0;
    end else if (w_press && !w_accept && !w_full) begin
      r_pend <= r_pend + 4'd1;
    end else if (w_accept && !w_press) begin
      r_pend <= r_pend - 4'd1;
    end
  end

  // Accepted-start counter, free-running wrap
  always_ff @(posedge clk) begin
    if (rst)           r_launches <= 8'd0;
    else if (w_accept) r_launches <= r_launches + 8'd1;
  end

  // Done-display counter: loaded on completion, counts down through HOLD
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
    end else if (r_state == S_WAIT_DONE && core_done) begin
      r_hold <= c_HOLD_LOAD;
    end else if (r_state == S_HOLD && r_hold != '0) begin
      r_hold <= r_hold - 1'b1;
    end
  end

  // Sticky error flags; a set event takes priority over a clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_press && !w_accept && w_full) r_ovf <= 1'b1;
      else if (clr_err)                   r_ovf <= 1'b0;
      if (w_wd_expire)                    r_timeout <= 1'b1;
      else if (clr_err)                   r_timeout <= 1'b0;
    end
  end

  assign pend_o     = r_pend;
  assign launches_o = r_launches;
  assign ovf_o      = r_ovf;
  assign timeout_o  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_start_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_start_sequencer
//  Purpose  : Directed self-checking bench for start_sequencer
//             (PEND_MAX=3, HOLD_CYCLES=4, TIMEOUT_CYCLES=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_start_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       db_in = 1'b0;
  logic       core_ready = 1'b0;
  logic       core_done = 1'b0;
  logic       clr_err = 1'b0;
  logic       start_o;
  logic       busy_o;
  logic       done_o;
  logic [3:0] pend_o;
  logic [7:0] launches_o;
  logic       ovf_o;
  logic       timeout_o;

  int checks   = 0;
  int failures = 0;

  start_sequencer #(
    .PEND_MAX       (3),
    .HOLD_CYCLES    (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .db_in      (db_in),
    .core_ready (core_ready),
    .core_done  (core_done),
    .clr_err    (clr_err),
    .start_o    (start_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .pend_o     (pend_o),
    .launches_o (launches_o),
    .ovf_o      (ovf_o),
    .timeout_o  (timeout_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs changed 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_start"},    int'(start_o),    0);
    chk({tag, "_busy"},     int'(busy_o),     0);
    chk({tag, "_done"},     int'(done_o),     0);
    chk({tag, "_pend"},     int'(pend_o),     0);
    chk({tag, "_launches"}, int'(launches_o), 0);
    chk({tag, "_ovf"},      int'(ovf_o),      0);
    chk({tag, "_timeout"},  int'(timeout_o),  0);
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    chk_idle_zero("reset");

    // Single press with a ready core
    core_ready = 1'b1;
    db_in = 1'b1;
    step();
    chk("t1_pend_e0", int'(pend_o), 1);
    chk("t1_start_e0", int'(start_o), 0);
    step();
    chk("t1_start", int'(start_o), 1);
    chk("t1_busy_launch", int'(busy_o), 1);
    db_in = 1'b0;
    step();
    chk("t1_start_drop", int'(start_o), 0);
    chk("t1_pend_acc", int'(pend_o), 0);
    chk("t1_launches", int'(launches_o), 1);
    chk("t1_busy_wait", int'(busy_o), 1);
    // Completion: done_o high for exactly 4 cycles
    core_ready = 1'b0;
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk("t1_done_c0", int'(done_o), 1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("t1_done_c%0d", i), int'(done_o), 1);
    end
    step();
    chk("t1_done_end", int'(done_o), 0);
    chk("t1_busy_end", int'(busy_o), 0);

    // Five presses against a stalled core: queue saturates at 3
    for (int i = 0; i < 5; i++) begin
      db_in = 1'b1;
      step();
      db_in = 1'b0;
      step();
    end
    chk("t2_pend_sat", int'(pend_o), 3);
    chk("t2_ovf", int'(ovf_o), 1);
    chk("t2_start_stall", int'(start_o), 1);
    chk("t2_launches", int'(launches_o), 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t2_ovf_clr", int'(ovf_o), 0);
    // Overflow set beats a simultaneous clear
    db_in = 1'b1;
    clr_err = 1'b1;
    step();
    chk("t2_ovf_set_wins", int'(ovf_o), 1);
    db_in = 1'b0;
    step();
    clr_err = 1'b0;
    chk("t2_ovf_clr2", int'(ovf_o), 0);

    // Accept with three queued, then back-to-back relaunch after HOLD
    core_ready = 1'b1;
    step();
    core_ready = 1'b0;
    chk("t3_pend_acc", int'(pend_o), 2);
    chk("t3_launches", int'(launches_o), 2);
    chk("t3_start_drop", int'(start_o), 0);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk("t3_done_c0", int'(done_o), 1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("t3_done_c%0d", i), int'(done_o), 1);
      chk($sformatf("t3_start_c%0d", i), int'(start_o), 0);
    end
    step();
    chk("t3_done_fall", int'(done_o), 0);
    chk("t3_start_rise", int'(start_o), 1);
    chk("t3_pend", int'(pend_o), 2);

    // Drain to pend=1, then press coincident with accept
    core_ready = 1'b1;
    step();
    core_ready = 1'b0;
    chk("t4_pend_pre", int'(pend_o), 1);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t4_start_pre", int'(start_o), 1);
    db_in = 1'b1;
    core_ready = 1'b1;
    step();
    db_in = 1'b0;
    core_ready = 1'b0;
    chk("t4_pend_same", int'(pend_o), 1);
    chk("t4_launches", int'(launches_o), 4);
    chk("t4_ovf_none", int'(ovf_o), 0);
    chk("t4_start_drop", int'(start_o), 0);

    // Core never completes: now in WAIT_DONE with one queued press
`ifdef START_SEQ_TIMEOUT_EN
    for (int i = 0; i < 7; i++) step();
    chk("t5_busy_pre", int'(busy_o), 1);
    chk("t5_timeout_pre", int'(timeout_o), 0);
    step();
    chk("t5_timeout", int'(timeout_o), 1);
    chk("t5_idle", int'(busy_o), 0);
    chk("t5_pend_kept", int'(pend_o), 1);
    step();
    chk("t5_relaunch", int'(start_o), 1);
    core_ready = 1'b1;
    step();
    core_ready = 1'b0;
    chk("t5_pend0", int'(pend_o), 0);
    for (int i = 0; i < 2; i++) begin
      db_in = 1'b1;
      step();
      db_in = 1'b0;
      step();
    end
`else
    for (int i = 0; i < 20; i++) step();
    chk("t5_busy_stuck", int'(busy_o), 1);
    chk("t5_timeout_zero", int'(timeout_o), 0);
    chk("t5_done_zero", int'(done_o), 0);
    db_in = 1'b1;
    step();
    db_in = 1'b0;
    step();
`endif

    // Reset in WAIT_DONE with two queued presses
    chk("t6_pend_pre", int'(pend_o), 2);
    chk("t6_busy_pre", int'(busy_o), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle_zero("t6_rst");
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk("t6_done_ignored", int'(done_o), 0);
    chk("t6_busy_ignored", int'(busy_o), 0);
    step();
    chk("t6_start_none", int'(start_o), 0);
    chk("t6_pend_none", int'(pend_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
